// File: rtl/cpu_output_serializer_if.sv
// Byte-wide valid/ready stream from the serializer toward a UART or debug host.
interface cpu_output_serializer_if;
    logic [7:0] byteData;
    logic       byteValid;
    logic       byteReady;

    modport master (output byteData, output byteValid, input byteReady);
    modport slave  (input byteData, input byteValid, output byteReady);
endinterface

// File: rtl/cpu_output_serializer.sv
// Buffers CPU write-back words in a FIFO and streams them out MSB byte first
// over a valid/ready byte interface; flags dropped captures with a sticky overflow.
module cpu_output_serializer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       outFlag,
    input  logic [WIDTH-1:0]           out,
    cpu_output_serializer_if.master    byte_if,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shift;
    logic [7:0]       r_byte_data;
    logic             r_byte_valid;

    state_t           w_state_next;
    logic [IW-1:0]    w_idx_next;
    logic [IW-1:0]    w_idx_inc;
    logic [7:0]       w_byte_data_next;
    logic             w_byte_valid_next;
    logic             w_push;
    logic             w_pop;
    logic             w_xfer;
    logic             w_last;
    logic [WIDTH-1:0] w_rd_word;
    logic [7:0]       w_bytes [NB];

    // Byte lanes of the shift register, lane 0 is the most significant byte.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign w_bytes[gi] = r_shift[WIDTH-1-8*gi -: 8];
        end
    endgenerate

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign overflow  = r_overflow;
    assign count     = r_count;
    assign w_push    = outFlag & ~full;
    assign w_rd_word = r_mem[r_rd_ptr];
    assign w_xfer    = r_byte_valid & byte_if.byteReady;
    assign w_last    = (r_idx == IW'(NB - 1));
    assign w_idx_inc = r_idx + 1'b1;

    assign byte_if.byteData  = r_byte_data;
    assign byte_if.byteValid = r_byte_valid;

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_pop             = 1'b0;
        w_byte_valid_next = r_byte_valid;
        w_byte_data_next  = r_byte_data;
        case (r_state)
            IDLE: begin
                if (!empty) begin
                    w_pop             = 1'b1;
                    w_idx_next        = '0;
                    w_state_next      = SEND;
                    w_byte_valid_next = 1'b1;
                    w_byte_data_next  = w_rd_word[WIDTH-1 -: 8];
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_idx_next       = w_idx_inc;
                        w_byte_data_next = w_bytes[w_idx_inc];
                    end else if (!empty) begin
                        // Chain straight into the next word so the stream has no bubble.
                        w_pop            = 1'b1;
                        w_idx_next       = '0;
                        w_byte_data_next = w_rd_word[WIDTH-1 -: 8];
                    end else begin
                        w_state_next      = IDLE;
                        w_byte_valid_next = 1'b0;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_shift      <= '0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_byte_data  <= w_byte_data_next;
            r_byte_valid <= w_byte_valid_next;
            if (w_pop) begin
                r_shift  <= w_rd_word;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Full is judged on the pre-edge count, so a same-cycle pop never rescues the word.
            if (outFlag && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= out;
        end
    end
endmodule

// File: tb/tb_cpu_output_serializer.sv
// Scoreboard bench: a queue-level model predicts bytes and flags, a monitor compares.
module tb_cpu_output_serializer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int NB    = WIDTH / 8;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   outFlag = 1'b0;
    logic [WIDTH-1:0]       out = '0;
    logic                   full, empty, overflow;
    logic [$clog2(DEPTH):0] count;

    cpu_output_serializer_if bif ();

    cpu_output_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .outFlag  (outFlag),
        .out      (out),
        .byte_if  (bif),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .count    (count)
    );

    always #5 clock = ~clock;

    // Reference model: words waiting in the FIFO, one word being sent, expected byte stream.
    logic [WIDTH-1:0] m_fifo [$];
    logic [7:0]       exp_q [$];
    bit               m_busy = 0;
    int               m_idx = 0;
    bit               m_ovf = 0;
    bit               done = 0;
    bit               timeout = 0;
    int               n_tests = 0;
    int               n_fail = 0;

    initial begin
        bif.byteReady = 1'b0;
    end

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_fifo.delete();
            exp_q.delete();
            m_busy = 0;
            m_idx  = 0;
            m_ovf  = 0;
        end else begin
            int pre;
            bit pop;
            pre = m_fifo.size();
            pop = 0;
            if (m_busy && bif.byteReady) begin
                if (m_idx < NB - 1) m_idx++;
                else if (pre > 0)   pop = 1;
                else                m_busy = 0;
            end else if (!m_busy && pre > 0) begin
                pop = 1;
            end
            if (pop) begin
                void'(m_fifo.pop_front());
                m_busy = 1;
                m_idx  = 0;
            end
            if (outFlag) begin
                if (pre < DEPTH) begin
                    m_fifo.push_back(out);
                    for (int b = 0; b < NB; b++) exp_q.push_back(out[WIDTH-1-8*b -: 8]);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks every negedge, plus an immediate check on an asynchronous reset.
    initial begin
        bit         prev_hold = 0;
        logic [7:0] prev_data = '0;
        forever begin
            @(negedge clock or negedge reset);
            if (clock === 1'b1) begin
                #1;
                chk("rst_valid", bif.byteValid, 0);
                chk("rst_data", bif.byteData, 0);
                chk("rst_count", count, 0);
                chk("rst_overflow", overflow, 0);
                chk("rst_empty", empty, 1);
                prev_hold = 0;
            end else begin
                chk("valid", bif.byteValid, m_busy);
                chk("count", count, m_fifo.size());
                chk("overflow", overflow, m_ovf);
                chk("full", full, m_fifo.size() == DEPTH);
                chk("empty", empty, m_fifo.size() == 0);
                if (prev_hold && bif.byteValid) chk("hold_data", bif.byteData, prev_data);
                if (bif.byteValid && bif.byteReady) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", bif.byteData, -1);
                    end else begin
                        chk("byte", bif.byteData, exp_q.pop_front());
                    end
                end
                prev_hold = bif.byteValid && !bif.byteReady;
                prev_data = bif.byteData;
                if (done) begin
                    chk("drain_timeout", timeout, 0);
                    chk("leftover_bytes", exp_q.size(), 0);
                    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                    $finish;
                end
            end
        end
    end

    task automatic cycle(input bit flag, input logic [WIDTH-1:0] data, input bit ready);
        @(posedge clock);
        #1;
        outFlag       = flag;
        out           = data;
        bif.byteReady = ready;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (!m_busy && m_fifo.size() == 0 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            cycle(0, '0, 1);
        end
        if (!ok) timeout = 1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Single capture
        cycle(1, 16'hA55A, 1);
        repeat (4) cycle(0, '0, 1);

        // Backpressure
        cycle(1, 16'h1234, 0);
        repeat (5) cycle(0, '0, 0);
        drain();

        // Fill and overflow
        for (int i = 1; i <= 10; i++) cycle(1, WIDTH'(i), 0);
        repeat (3) cycle(0, '0, 0);
        drain();

        // Back-to-back streaming across pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) cycle(1, WIDTH'(16'h1100 + r * 16 + i), 1);
            repeat (8) cycle(0, '0, 1);
        end

        // Push and pop in the same cycle at count 3
        for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(16'h0101 * i), 0);
        cycle(0, '0, 1);
        cycle(1, 16'h0505, 1);
        cycle(0, '0, 0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 9) < 6);
        drain();

        // Asynchronous reset mid-transfer
        cycle(1, 16'hBEEF, 0);
        cycle(1, 16'hCAFE, 0);
        cycle(0, '0, 0);
        @(posedge clock);
        #3 reset = 1'b0;
        outFlag = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        cycle(1, 16'h7E81, 1);
        drain();

        done = 1;
        repeat (5) @(posedge clock);
        $display("FAIL monitor: got no summary expected summary");
        $fatal(1);
    end
endmodule
